// File: rtl/spike_class_readout.sv
// spike_class_readout: counts output spikes per class over a sample window,
// picks the winning class (argmax, ties to lowest index), compares it with the
// latched one-hot label and keeps running sample/hit statistics.
//
// Output handshake: o_valid is a one-cycle strobe with no ready/back-pressure.
// o_class, o_correct and o_timeout are valid while o_valid is high and hold
// until the next strobe. o_sample_count/o_hit_count reflect a report from the
// cycle after its o_valid strobe.
module spike_class_readout #(
  parameter int p_n       = 10,
  parameter int p_idx_w   = 4,
  parameter int p_cnt_w   = 8,
  parameter int p_stat_w  = 16,
  parameter int p_timeout = 1023
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [p_n:1]        i_spike,
  input  logic [p_n:1]        i_label,
  input  logic                i_sample_start,
  input  logic                i_sample_end,
  input  logic                i_clear_stats,
  output logic                o_valid,
  output logic [p_idx_w-1:0]  o_class,
  output logic                o_correct,
  output logic                o_timeout,
  output logic [p_stat_w-1:0] o_sample_count,
  output logic [p_stat_w-1:0] o_hit_count
);

  localparam int p_tmr_w = $clog2(p_timeout + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECIDE  = 2'd2,
    S_REPORT  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [p_cnt_w-1:0]   cnt_q [1:p_n];
  logic [p_n:1]         label_q, pend_label_q;
  logic                 pend_q;
  logic [p_tmr_w-1:0]   timer_q;
  logic                 to_flag_q;
  logic [p_idx_w-1:0]   scan_q, best_idx_q;
  logic [p_cnt_w-1:0]   best_cnt_q;
  logic [p_idx_w-1:0]   class_q;
  logic                 correct_q, timeout_q;
  logic [p_stat_w-1:0]  sample_q, hit_q;

  logic                 timer_done;
  logic [p_cnt_w-1:0]   cur_cnt;
  logic                 upd;
  logic [p_idx_w-1:0]   final_idx;
  logic                 hit_d;

  assign timer_done = (timer_q == p_tmr_w'(p_timeout - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a start inside COLLECT restarts the window and beats end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_sample_start || pend_q) state_d = S_COLLECT;
      S_COLLECT: begin
        if (i_sample_start)                  state_d = S_COLLECT;
        else if (i_sample_end || timer_done) state_d = S_DECIDE;
      end
      S_DECIDE:  if (scan_q == p_idx_w'(p_n)) state_d = S_REPORT;
      S_REPORT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Scan step: select the counter under the scan pointer and the candidate winner
  always_comb begin
    cur_cnt = '0;
    for (int i = 1; i <= p_n; i++) begin
      if (scan_q == p_idx_w'(i)) cur_cnt = cnt_q[i];
    end
    upd       = (cur_cnt > best_cnt_q);
    final_idx = upd ? scan_q : best_idx_q;
  end

  // Label bit test for the candidate winner; class 0 never hits
  always_comb begin
    hit_d = 1'b0;
    for (int i = 1; i <= p_n; i++) begin
      if (final_idx == p_idx_w'(i)) hit_d = label_q[i];
    end
  end

  // Datapath: spike counters, timer, label/pending registers, scan, results, stats
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 1; i <= p_n; i++) cnt_q[i] <= '0;
      label_q      <= '0;
      pend_label_q <= '0;
      pend_q       <= 1'b0;
      timer_q      <= '0;
      to_flag_q    <= 1'b0;
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      class_q      <= '0;
      correct_q    <= 1'b0;
      timeout_q    <= 1'b0;
      sample_q     <= '0;
      hit_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_sample_start || pend_q) begin
            for (int i = 1; i <= p_n; i++) cnt_q[i] <= '0;
            timer_q   <= '0;
            to_flag_q <= 1'b0;
            label_q   <= i_sample_start ? i_label : pend_label_q;
            pend_q    <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (i_sample_start) begin
            for (int i = 1; i <= p_n; i++) cnt_q[i] <= '0;
            timer_q   <= '0;
            to_flag_q <= 1'b0;
            label_q   <= i_label;
          end else begin
            for (int i = 1; i <= p_n; i++) begin
              if (i_spike[i] && (cnt_q[i] != {p_cnt_w{1'b1}}))
                cnt_q[i] <= cnt_q[i] + p_cnt_w'(1);
            end
            timer_q    <= timer_q + p_tmr_w'(1);
            to_flag_q  <= timer_done && !i_sample_end;
            scan_q     <= p_idx_w'(1);
            best_idx_q <= '0;
            best_cnt_q <= '0;
          end
        end
        S_DECIDE: begin
          best_idx_q <= final_idx;
          if (upd) best_cnt_q <= cur_cnt;
          scan_q <= scan_q + p_idx_w'(1);
          if (scan_q == p_idx_w'(p_n)) begin
            class_q   <= final_idx;
            correct_q <= hit_d;
            timeout_q <= to_flag_q;
          end
          if (i_sample_start) begin
            pend_q       <= 1'b1;
            pend_label_q <= i_label;
          end
        end
        S_REPORT: begin
          if (sample_q != {p_stat_w{1'b1}}) sample_q <= sample_q + p_stat_w'(1);
          if (correct_q && (hit_q != {p_stat_w{1'b1}})) hit_q <= hit_q + p_stat_w'(1);
          if (i_sample_start) begin
            pend_q       <= 1'b1;
            pend_label_q <= i_label;
          end
        end
        default: ;
      endcase
      // Clearing the statistics overrides a coincident report increment
      if (i_clear_stats) begin
        sample_q <= '0;
        hit_q    <= '0;
      end
    end
  end

  assign o_valid        = (state_q == S_REPORT);
  assign o_class        = class_q;
  assign o_correct      = correct_q;
  assign o_timeout      = timeout_q;
  assign o_sample_count = sample_q;
  assign o_hit_count    = hit_q;

endmodule

// File: tb/tb_spike_class_readout.sv
// Bench for spike_class_readout: scoreboarded decisions with latency, timeout,
// tie/saturation/abort/pending/clear/reset scenarios and random windows.
module tb_spike_class_readout;

  logic        clk;
  logic        rst_n;
  logic [10:1] spike;
  logic [10:1] label;
  logic        sample_start;
  logic        sample_end;
  logic        clear_stats;
  logic        valid;
  logic [3:0]  cls;
  logic        correct;
  logic        timeout;
  logic [15:0] sample_count;
  logic [15:0] hit_count;

  spike_class_readout dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_spike        (spike),
    .i_label        (label),
    .i_sample_start (sample_start),
    .i_sample_end   (sample_end),
    .i_clear_stats  (clear_stats),
    .o_valid        (valid),
    .o_class        (cls),
    .o_correct      (correct),
    .o_timeout      (timeout),
    .o_sample_count (sample_count),
    .o_hit_count    (hit_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [10:1] oh(input int k);
    logic [10:1] v;
    v = '0;
    if (k >= 1 && k <= 10) v[k] = 1'b1;
    return v;
  endfunction

  // Reference model state: {timeout, correct, class[3:0], due_cycle[31:0]}
  logic [37:0] exp_q[$];
  int          m_cnt [1:10];
  logic [10:1] m_label;
  bit          m_coll = 0;
  int          m_timer = 0;
  int          m_samples = 0;
  int          m_hits = 0;
  bit          stat_chk = 0;
  bit          run_chk = 0;

  task automatic model_decide(input bit to);
    int best, best_cnt;
    logic corr;
    best = 0;
    best_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (m_cnt[i] > best_cnt) begin
        best = i;
        best_cnt = m_cnt[i];
      end
    end
    corr = (best != 0) && m_label[best];
    exp_q.push_back({to, corr, 4'(best), 32'(cyc + 11)});
  endtask

  // Driver: apply one cycle of inputs and advance the model accordingly
  task automatic drive(input logic [10:1] spk, input logic st, input logic [10:1] lab,
                       input logic en, input logic clr);
    spike = spk;
    sample_start = st;
    label = lab;
    sample_end = en;
    clear_stats = clr;
    if (st) begin
      for (int i = 1; i <= 10; i++) m_cnt[i] = 0;
      m_label = lab;
      m_coll = 1;
      m_timer = 0;
    end else if (m_coll) begin
      for (int i = 1; i <= 10; i++) begin
        if (spk[i] && m_cnt[i] < 255) m_cnt[i]++;
      end
      if (en || m_timer == 1022) begin
        model_decide(!en);
        m_coll = 0;
      end else begin
        m_timer++;
      end
    end
    @(posedge clk);
    #1;
    spike = '0;
    sample_start = 1'b0;
    label = '0;
    sample_end = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    check("drain", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  // Scoreboard: pop and compare on every decision strobe; track statistics
  always @(negedge clk) begin
    if (run_chk) begin
      logic [37:0] e;
      if (stat_chk) begin
        check("sample_count", 32'(sample_count), 32'(m_samples));
        check("hit_count", 32'(hit_count), 32'(m_hits));
        stat_chk = 0;
      end
      if (!rst_n) begin
        m_samples = 0;
        m_hits = 0;
        stat_chk = 1;
      end else begin
        if (valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("class", 32'(cls), 32'(e[35:32]));
            check("correct", 32'(correct), 32'(e[36]));
            check("timeout", 32'(timeout), 32'(e[37]));
            check("latency", 32'(cyc), e[31:0]);
            if (m_samples < 65535) m_samples++;
            if (e[36] && m_hits < 65535) m_hits++;
            stat_chk = 1;
          end
        end
        if (clear_stats) begin
          m_samples = 0;
          m_hits = 0;
          stat_chk = 1;
        end
      end
    end
  end

  initial begin
    logic [10:1] v;
    int lab_k, len;
    rst_n = 1'b0;
    spike = '0;
    label = '0;
    sample_start = 1'b0;
    sample_end = 1'b0;
    clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_class", 32'(cls), 32'd0);
    check("rst_correct", 32'(correct), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_samples", 32'(sample_count), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_chk = 1;

    // Spikes and a stray end while idle are ignored
    drive(oh(3), 1'b0, '0, 1'b1, 1'b0);
    idle(3);

    // Basic: class 3 x5, class 7 x2 over 50 cycles, label class 3
    drive(oh(1), 1'b1, oh(3), 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      v = '0;
      if (i % 10 == 2) v = v | oh(3);
      if (i == 7 || i == 33) v = v | oh(7);
      drive(v, 1'b0, '0, 1'b0, 1'b0);
    end
    drive('0, 1'b0, '0, 1'b1, 1'b0);
    drain();
    check("basic_samples", 32'(sample_count), 32'd1);
    check("basic_hits", 32'(hit_count), 32'd1);

    // Tie between classes 2 and 5, label class 5
    drive('0, 1'b1, oh(5), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(oh(5), 1'b0, '0, 1'b0, 1'b0);
      drive(oh(2), 1'b0, '0, 1'b0, 1'b0);
    end
    drive('0, 1'b0, '0, 1'b1, 1'b0);
    drain();
    check("tie_samples", 32'(sample_count), 32'd2);
    check("tie_hits", 32'(hit_count), 32'd1);

    // Empty window
    drive('0, 1'b1, oh(1), 1'b0, 1'b0);
    idle(10);
    drive('0, 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Forced close by timeout, class 1 x3
    drive('0, 1'b1, oh(1), 1'b0, 1'b0);
    for (int n = 0; n < 1023; n++) begin
      drive((n == 0 || n == 500 || n == 1022) ? oh(1) : '0, 1'b0, '0, 1'b0, 1'b0);
    end
    drain();

    // Saturation: class 4 x300, class 9 x256, label class 9
    drive('0, 1'b1, oh(9), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) drive(oh(4) | ((i < 256) ? oh(9) : '0), 1'b0, '0, 1'b0, 1'b0);
    drive('0, 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Abort: second start discards the first window's spikes
    drive('0, 1'b1, oh(2), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(oh(2), 1'b0, '0, 1'b0, 1'b0);
    drive(oh(2), 1'b1, oh(8), 1'b1, 1'b0);
    drive(oh(8), 1'b0, '0, 1'b0, 1'b0);
    drive(oh(8), 1'b0, '0, 1'b0, 1'b0);
    drive('0, 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Pending start during DECIDE, its label used for the next window
    drive('0, 1'b1, oh(2), 1'b0, 1'b0);
    drive(oh(2), 1'b0, '0, 1'b0, 1'b0);
    drive(oh(2), 1'b0, '0, 1'b1, 1'b0);
    idle(3);
    drive('0, 1'b1, oh(6), 1'b0, 1'b0);
    idle(20);
    for (int i = 0; i < 3; i++) drive(oh(6), 1'b0, '0, 1'b0, 1'b0);
    drive(oh(1), 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Clear coincident with REPORT: report still seen, increments lost
    drive('0, 1'b1, oh(4), 1'b0, 1'b0);
    drive(oh(4), 1'b0, '0, 1'b1, 1'b0);
    idle(10);
    drive('0, 1'b0, '0, 1'b0, 1'b1);
    drain();
    check("clr_samples", 32'(sample_count), 32'd0);

    // Non-one-hot label: plain bit test
    drive('0, 1'b1, 10'h3FF, 1'b0, 1'b0);
    drive(oh(5), 1'b0, '0, 1'b1, 1'b0);
    drain();

    // Random windows
    for (int r = 0; r < 6; r++) begin
      lab_k = $urandom_range(1, 10);
      len = $urandom_range(15, 40);
      drive('0, 1'b1, oh(lab_k), 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
        v = 10'($urandom_range(0, 1023)) & 10'($urandom_range(0, 1023));
        drive(v, 1'b0, '0, (i == len - 1), 1'b0);
      end
      drain();
    end

    // Reset in the middle of DECIDE: no report, everything back to zero
    drive('0, 1'b1, oh(3), 1'b0, 1'b0);
    drive(oh(3), 1'b0, '0, 1'b1, 1'b0);
    idle(4);
    rst_n = 1'b0;
    exp_q.delete();
    m_coll = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_class", 32'(cls), 32'd0);
    check("midrst_correct", 32'(correct), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    check("midrst_samples", 32'(sample_count), 32'd0);
    @(posedge clk);
    #1;
    idle(20);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
